// File: rtl/mmio_pkg.sv
// Shared address map, read-source encoding and byte-lane merge helper
// for the data memory / machine timer slave.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE       = 32'hF000_0000;
    localparam logic [3:0]  MTIME_LO_OFF    = 4'h0;
    localparam logic [3:0]  MTIME_HI_OFF    = 4'h4;
    localparam logic [3:0]  MTIMECMP_LO_OFF = 4'h8;
    localparam logic [3:0]  MTIMECMP_HI_OFF = 4'hC;
    localparam logic [3:0]  RAM_REGION      = 4'h0;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_MMIO = 2'd2
    } rd_src_e;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) res[8*k +: 8] = new_word[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mtimer.sv
// Machine timer: prescaled 64-bit mtime, mtimecmp, registered interrupt
// level and a combinational register read mux for the MMIO window.
module mtimer
    import mmio_pkg::*;
#(
    parameter int TIMER_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we,
    input  logic [3:0]  offset,
    input  logic [3:0]  wsel_byte,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int            PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          irq_q, irq_d;

    // A software write to either mtime half wins over the tick and restarts the prescaler.
    always_comb begin
        presc_d    = presc_q;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (we && offset == MTIME_LO_OFF) begin
            mtime_d[31:0] = merge_lanes(mtime_q[31:0], wdata, wsel_byte);
            presc_d       = '0;
        end else if (we && offset == MTIME_HI_OFF) begin
            mtime_d[63:32] = merge_lanes(mtime_q[63:32], wdata, wsel_byte);
            presc_d        = '0;
        end else if (presc_q == PRESC_MAX) begin
            mtime_d = mtime_q + 64'd1;
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
        if (we && offset == MTIMECMP_LO_OFF)
            mtimecmp_d[31:0] = merge_lanes(mtimecmp_q[31:0], wdata, wsel_byte);
        if (we && offset == MTIMECMP_HI_OFF)
            mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], wdata, wsel_byte);
        irq_d = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (offset)
            MTIME_LO_OFF:    rdata = mtime_q[31:0];
            MTIME_HI_OFF:    rdata = mtime_q[63:32];
            MTIMECMP_LO_OFF: rdata = mtimecmp_q[31:0];
            MTIMECMP_HI_OFF: rdata = mtimecmp_q[63:32];
            default:         rdata = 32'h0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory slave: byte-writable block RAM with one-cycle read
// latency plus the memory-mapped machine timer.
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int TIMER_DIV   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] addr_i,
    input  logic        read_i,
    input  logic [3:0]  wsel_byte_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        timer_irq_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   ram_dout;
    logic [AW-1:0] ram_idx;
    logic          ram_sel, mmio_sel, req_rd, req_wr;
    logic [31:0]   timer_rdata;
    logic [31:0]   mmio_rdata_q, mmio_rdata_d;
    rd_src_e       src_q, src_d;
    logic          unused_addr;

    // Requests seen while reset is high are dropped entirely.
    always_comb begin
        ram_sel  = (addr_i[31:28] == RAM_REGION);
        mmio_sel = (addr_i[31:4] == MMIO_BASE[31:4]);
        req_rd   = en_i && read_i && !rst_i;
        req_wr   = en_i && (wsel_byte_i != 4'b0000) && !rst_i;
        ram_idx  = addr_i[AW+1:2];
    end

    assign unused_addr = ^{addr_i[27:AW+2], addr_i[1:0]};

    // Block-RAM template: per-byte write, read-first synchronous output register.
    always_ff @(posedge clk_i) begin
        if (req_wr && ram_sel) begin
            for (int k = 0; k < 4; k++) begin
                if (wsel_byte_i[k]) mem[ram_idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
        if (req_rd && ram_sel) ram_dout <= mem[ram_idx];
    end

    mtimer #(.TIMER_DIV(TIMER_DIV)) u_mtimer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we        (req_wr && mmio_sel),
        .offset    ({addr_i[3:2], 2'b00}),
        .wsel_byte (wsel_byte_i),
        .wdata     (wdata_i),
        .rdata     (timer_rdata),
        .irq       (timer_irq_o)
    );

    // Each source keeps its last read word, so rdata_o holds when nothing is read.
    always_comb begin
        src_d        = src_q;
        mmio_rdata_d = mmio_rdata_q;
        if (req_rd) begin
            if (ram_sel) begin
                src_d = SRC_RAM;
            end else if (mmio_sel) begin
                src_d        = SRC_MMIO;
                mmio_rdata_d = timer_rdata;
            end else begin
                src_d = SRC_NONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q        <= SRC_NONE;
            mmio_rdata_q <= 32'h0;
        end else begin
            src_q        <= src_d;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    always_comb begin
        case (src_q)
            SRC_RAM:  rdata_o = ram_dout;
            SRC_MMIO: rdata_o = mmio_rdata_q;
            default:  rdata_o = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus randomized
// traffic compared against a behavioural memory/timer model.
module tb_dmem_mmio;

    logic        clk_i, rst_i, en_i, read_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  wsel_byte_i;
    logic [31:0] rdata_o;
    logic        timer_irq_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ram_m [int];
    logic [63:0] mtime_m, mtimecmp_m;
    logic [31:0] exp_rdata;
    logic        exp_irq;

    dmem_mmio #(.DEPTH_WORDS(4096), .TIMER_DIV(1)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .addr_i      (addr_i),
        .read_i      (read_i),
        .wsel_byte_i (wsel_byte_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .timer_irq_o (timer_irq_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) if (sel[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx;
        idx = int'(addr[13:2]);
        if (addr[31:28] == 4'h0) return ram_m.exists(idx) ? ram_m[idx] : 32'hx;
        if (addr[31:4] == 28'hF000000) begin
            case (addr[3:2])
                2'd0: return mtime_m[31:0];
                2'd1: return mtime_m[63:32];
                2'd2: return mtimecmp_m[31:0];
                default: return mtimecmp_m[63:32];
            endcase
        end
        return 32'h0;
    endfunction

    // Drive one request for one clock and advance the model by one cycle.
    task automatic do_cycle(input logic rst, input logic en, input logic rd,
                            input logic [31:0] addr, input logic [3:0] wsel,
                            input logic [31:0] wdata);
        logic irq_next;
        logic mtime_written;
        int   idx;
        rst_i = rst; en_i = en; read_i = rd; addr_i = addr;
        wsel_byte_i = wsel; wdata_i = wdata;
        idx = int'(addr[13:2]);
        irq_next = (mtime_m >= mtimecmp_m);
        mtime_written = 1'b0;
        if (!rst && en && rd) exp_rdata = model_read(addr);
        if (!rst && en && wsel != 4'b0000) begin
            if (addr[31:28] == 4'h0) begin
                ram_m[idx] = lanes(ram_m.exists(idx) ? ram_m[idx] : 32'h0, wdata, wsel);
            end else if (addr[31:4] == 28'hF000000) begin
                case (addr[3:2])
                    2'd0: begin mtime_m[31:0]  = lanes(mtime_m[31:0],  wdata, wsel); mtime_written = 1'b1; end
                    2'd1: begin mtime_m[63:32] = lanes(mtime_m[63:32], wdata, wsel); mtime_written = 1'b1; end
                    2'd2: mtimecmp_m[31:0]  = lanes(mtimecmp_m[31:0],  wdata, wsel);
                    default: mtimecmp_m[63:32] = lanes(mtimecmp_m[63:32], wdata, wsel);
                endcase
            end
        end
        if (!mtime_written) mtime_m = mtime_m + 64'd1;
        @(posedge clk_i);
        #1;
        if (rst) begin
            exp_rdata  = 32'h0;
            mtime_m    = 64'h0;
            mtimecmp_m = '1;
            exp_irq    = 1'b0;
        end else begin
            exp_irq = irq_next;
        end
        rst_i = 1'b0; en_i = 1'b0; read_i = 1'b0; wsel_byte_i = 4'b0000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
    endtask

    task automatic test_reset;
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'h0) begin n_errors++; $display("[TB] FAIL reset_rdata: got %h want %h", rdata_o, 32'h0); end
        n_checks++;
        if (timer_irq_o !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_irq: got %b want 0", timer_irq_o); end
        do_cycle(1'b0, 1'b1, 1'b1, 32'hF000_0000, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'h0) begin n_errors++; $display("[TB] FAIL reset_mtime: got %h want %h", rdata_o, 32'h0); end
        do_cycle(1'b0, 1'b1, 1'b1, 32'hF000_0008, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'hFFFF_FFFF) begin n_errors++; $display("[TB] FAIL reset_mtimecmp: got %h want %h", rdata_o, 32'hFFFF_FFFF); end
    endtask

    task automatic test_ram_basic;
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0100, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'hDEAD_BEEF) begin n_errors++; $display("[TB] FAIL ram_basic: got %h want %h", rdata_o, 32'hDEAD_BEEF); end
        idle(2);
        n_checks++;
        if (rdata_o !== 32'hDEAD_BEEF) begin n_errors++; $display("[TB] FAIL ram_hold: got %h want %h", rdata_o, 32'hDEAD_BEEF); end
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0400_0103, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'hDEAD_BEEF) begin n_errors++; $display("[TB] FAIL ram_alias: got %h want %h", rdata_o, 32'hDEAD_BEEF); end
    endtask

    task automatic test_byte_lanes;
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0000_0200, 4'b1111, 32'h1122_3344);
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0000_0200, 4'b0100, 32'h00AA_0000);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'h11AA_3344) begin n_errors++; $display("[TB] FAIL byte_lanes: got %h want %h", rdata_o, 32'h11AA_3344); end
    endtask

    task automatic test_read_first;
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0000_0300, 4'b1111, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0300, 4'b1111, 32'h5);
        n_checks++;
        if (rdata_o !== 32'h0) begin n_errors++; $display("[TB] FAIL read_first_old: got %h want %h", rdata_o, 32'h0); end
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0300, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'h5) begin n_errors++; $display("[TB] FAIL read_first_new: got %h want %h", rdata_o, 32'h5); end
    endtask

    task automatic test_unmapped;
        do_cycle(1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0100, 4'b0000, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'h0) begin n_errors++; $display("[TB] FAIL unmapped_read: got %h want %h", rdata_o, 32'h0); end
        do_cycle(1'b0, 1'b1, 1'b0, 32'h8000_0000, 4'b1111, 32'h1234_5678);
        do_cycle(1'b0, 1'b1, 1'b0, 32'hF000_0010, 4'b1111, 32'h1234_5678);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0000, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'hCAFE_F00D) begin n_errors++; $display("[TB] FAIL unmapped_write: got %h want %h", rdata_o, 32'hCAFE_F00D); end
        do_cycle(1'b0, 1'b1, 1'b1, 32'hF000_0014, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'h0) begin n_errors++; $display("[TB] FAIL unmapped_mmio_read: got %h want %h", rdata_o, 32'h0); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        for (int i = 0; i < 6; i++) begin
            a = 32'h0000_0800 + 32'(i * 4);
            do_cycle(1'b0, 1'b1, 1'b0, a, 4'b1111, 32'hA5A5_0000 + 32'(i));
        end
        for (int i = 0; i < 6; i++) begin
            a = 32'h0000_0800 + 32'(i * 4);
            do_cycle(1'b0, 1'b1, 1'b1, a, 4'b0000, 32'h0);
            n_checks++;
            if (rdata_o !== 32'hA5A5_0000 + 32'(i)) begin
                n_errors++;
                $display("[TB] FAIL back_to_back[%0d]: got %h want %h", i, rdata_o, 32'hA5A5_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_timer_count;
        idle(8);
        do_cycle(1'b0, 1'b1, 1'b1, 32'hF000_0000, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== exp_rdata) begin n_errors++; $display("[TB] FAIL mtime_count: got %h want %h", rdata_o, exp_rdata); end
        do_cycle(1'b0, 1'b1, 1'b0, 32'hF000_0000, 4'b1111, 32'hFFFF_FFFF);
        do_cycle(1'b0, 1'b1, 1'b1, 32'hF000_0004, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'h0) begin n_errors++; $display("[TB] FAIL mtime_lo_no_carry: got %h want %h", rdata_o, 32'h0); end
        do_cycle(1'b0, 1'b1, 1'b1, 32'hF000_0000, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== exp_rdata) begin n_errors++; $display("[TB] FAIL mtime_lo_wrap: got %h want %h", rdata_o, exp_rdata); end
        do_cycle(1'b0, 1'b1, 1'b1, 32'hF000_0004, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== exp_rdata) begin n_errors++; $display("[TB] FAIL mtime_hi_after_wrap: got %h want %h", rdata_o, exp_rdata); end
    endtask

    task automatic test_timer_irq;
        int rise_cycle;
        int reach_cycle;
        do_cycle(1'b0, 1'b1, 1'b0, 32'hF000_0004, 4'b1111, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b0, 32'hF000_0000, 4'b1111, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b0, 32'hF000_000C, 4'b1111, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b0, 32'hF000_0008, 4'b1111, 32'd20);
        rise_cycle = -1;
        reach_cycle = -1;
        for (int c = 0; c < 30; c++) begin
            if (reach_cycle < 0 && mtime_m >= 64'd20) reach_cycle = c;
            idle(1);
            n_checks++;
            if (timer_irq_o !== exp_irq) begin n_errors++; $display("[TB] FAIL irq_cycle[%0d]: got %b want %b", c, timer_irq_o, exp_irq); end
            if (rise_cycle < 0 && timer_irq_o === 1'b1) rise_cycle = c;
        end
        n_checks++;
        if (rise_cycle != reach_cycle) begin n_errors++; $display("[TB] FAIL irq_rise_time: rose at %0d want %0d", rise_cycle, reach_cycle); end
        do_cycle(1'b0, 1'b1, 1'b0, 32'hF000_000C, 4'b1111, 32'hFFFF_FFFF);
        n_checks++;
        if (timer_irq_o !== 1'b1) begin n_errors++; $display("[TB] FAIL irq_drop_early: got %b want 1", timer_irq_o); end
        idle(1);
        n_checks++;
        if (timer_irq_o !== 1'b0) begin n_errors++; $display("[TB] FAIL irq_drop: got %b want 0", timer_irq_o); end
    endtask

    task automatic test_reset_mid;
        do_cycle(1'b0, 1'b1, 1'b0, 32'hF000_000C, 4'b1111, 32'h0);
        idle(2);
        n_checks++;
        if (timer_irq_o !== 1'b1) begin n_errors++; $display("[TB] FAIL pre_reset_irq: got %b want 1", timer_irq_o); end
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0100, 4'b0000, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'h0) begin n_errors++; $display("[TB] FAIL mid_reset_rdata: got %h want %h", rdata_o, 32'h0); end
        n_checks++;
        if (timer_irq_o !== 1'b0) begin n_errors++; $display("[TB] FAIL mid_reset_irq: got %b want 0", timer_irq_o); end
        do_cycle(1'b0, 1'b1, 1'b1, 32'hF000_0000, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'h0) begin n_errors++; $display("[TB] FAIL mid_reset_mtime: got %h want %h", rdata_o, 32'h0); end
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0100, 4'b0000, 32'h0);
        n_checks++;
        if (rdata_o !== 32'hDEAD_BEEF) begin n_errors++; $display("[TB] FAIL mid_reset_ram_kept: got %h want %h", rdata_o, 32'hDEAD_BEEF); end
    endtask

    task automatic test_random;
        logic [31:0] a, wd;
        logic [3:0]  ws;
        logic        rd, rs;
        int          kind;
        for (int i = 0; i < 8; i++)
            do_cycle(1'b0, 1'b1, 1'b0, 32'h0000_1000 + 32'(i * 4), 4'b1111, $urandom);
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5)
                a = {4'h0, 10'($urandom), 12'h400 + 12'($urandom_range(0, 7) * 4), 2'($urandom)} | 32'h0000_1000;
            else if (kind <= 8)
                a = 32'hF000_0000 | 32'($urandom_range(0, 15));
            else
                a = {4'($urandom_range(1, 14)), 28'($urandom)};
            a[13:12] = (kind <= 5) ? 2'b01 : a[13:12];
            rd = 1'($urandom);
            ws = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            wd = $urandom;
            rs = ($urandom_range(0, 59) == 0);
            if (rs) ws = 4'b0000;
            do_cycle(rs, 1'b1, rd, a, ws, wd);
            if (!$isunknown(exp_rdata)) begin
                n_checks++;
                if (rdata_o !== exp_rdata) begin
                    n_errors++;
                    $display("[TB] FAIL random_rdata[%0d] addr=%h: got %h want %h", n, a, rdata_o, exp_rdata);
                end
            end
            n_checks++;
            if (timer_irq_o !== exp_irq) begin
                n_errors++;
                $display("[TB] FAIL random_irq[%0d]: got %b want %b", n, timer_irq_o, exp_irq);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b0; read_i = 1'b0; addr_i = 32'h0;
        wsel_byte_i = 4'b0000; wdata_i = 32'h0;
        mtime_m = 64'h0; mtimecmp_m = '1; exp_rdata = 32'h0; exp_irq = 1'b0;
        test_reset();
        test_ram_basic();
        test_byte_lanes();
        test_read_first();
        test_unmapped();
        test_back_to_back();
        test_timer_irq();
        test_timer_count();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
